// File: rtl/accbuf_arb_if.sv
// Accumulation-buffer arbiter bus: per-channel result strobes in, buffer
// write port and per-channel status out.
//   acc_valid/acc_x/acc_y : channel results (no backpressure)
//   we/addr/data          : buffer write port
//   count/full/drop_cnt   : per-channel words written, region full, drops
//   ovf                   : sticky drop flag
interface accbuf_arb_if #(
    parameter int ADDRWIDTH = 12
);
    logic [3:0]                  acc_valid;
    logic [3:0][31:0]            acc_x;
    logic [3:0][31:0]            acc_y;
    logic                        we;
    logic [ADDRWIDTH-1:0]        addr;
    logic [63:0]                 data;
    logic [3:0][ADDRWIDTH-2:0]   count;
    logic [3:0]                  full;
    logic [3:0][15:0]            drop_cnt;
    logic                        ovf;

    modport master (
        output acc_valid, acc_x, acc_y,
        input  we, addr, data, count, full, drop_cnt, ovf
    );

    modport slave (
        input  acc_valid, acc_x, acc_y,
        output we, addr, data, count, full, drop_cnt, ovf
    );
endinterface

// File: rtl/accbuf_arb.sv
// Four-channel accumulation-buffer write arbiter with per-channel holding
// FIFOs. Ports: clk, reset (async, high), resetacc (sync clear), bus (slave).
module accbuf_arb #(
    parameter int ADDRWIDTH = 12,
    parameter int FIFODEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          resetacc,
    accbuf_arb_if.slave   bus
);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int CW = ADDRWIDTH - 1;
    localparam logic [CW-1:0] REGION = CW'(2 ** (ADDRWIDTH - 2));

    logic [63:0]          mem [4][FIFODEPTH];
    logic [3:0][PW:0]     wr_ptr;
    logic [3:0][PW:0]     rd_ptr;
    logic [3:0]           nonempty;
    logic [3:0]           fifo_full;
    logic [3:0]           push;
    logic [3:0]           pop;
    logic [3:0]           push_drop;
    logic [3:0]           pop_drop;
    logic [3:0]           full;
    logic [3:0][15:0]     drop_next;

    logic [1:0]           last_grant;
    logic [1:0]           gnt;
    logic [1:0]           cand;
    logic                 gnt_vld;
    logic                 wr_sel;

    logic [3:0][CW-1:0]   count_q;
    logic [3:0][15:0]     drop_q;
    logic                 ovf_q;
    logic                 we_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [63:0]          data_q;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            nonempty[c]  = wr_ptr[c] != rd_ptr[c];
            fifo_full[c] = (wr_ptr[c][PW] != rd_ptr[c][PW]) &&
                           (wr_ptr[c][PW-1:0] == rd_ptr[c][PW-1:0]);
            full[c]      = count_q[c] == REGION;
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = last_grant;
        cand    = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!gnt_vld && nonempty[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    assign wr_sel = gnt_vld && !full[gnt];

    // A full FIFO that is popped this cycle still has room for the push.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            pop[c]       = gnt_vld && (gnt == 2'(c));
            push[c]      = bus.acc_valid[c] && !resetacc &&
                           (!fifo_full[c] || pop[c]);
            push_drop[c] = bus.acc_valid[c] && !resetacc &&
                           fifo_full[c] && !pop[c];
            pop_drop[c]  = pop[c] && full[c];
        end
    end

    // A channel may drop on both the input and the write side at once.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            logic [16:0] sum;
            sum = {1'b0, drop_q[c]} + 17'(push_drop[c]) +
                  17'(pop_drop[c]);
            drop_next[c] = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c][PW-1:0]] <=
                    {bus.acc_x[c], bus.acc_y[c]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            last_grant <= 2'd3;
        end else if (resetacc) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            last_grant <= 2'd3;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + (PW+1)'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + (PW+1)'(1);
                end
                if (pop[c] && !full[c]) begin
                    count_q[c] <= count_q[c] + CW'(1);
                end
                drop_q[c] <= drop_next[c];
            end
            ovf_q <= ovf_q | (|push_drop) | (|pop_drop);
            we_q  <= wr_sel;
            if (wr_sel) begin
                addr_q <= {gnt, count_q[gnt][ADDRWIDTH-3:0]};
                data_q <= mem[gnt][rd_ptr[gnt][PW-1:0]];
            end
            if (gnt_vld) begin
                last_grant <= gnt;
            end
        end
    end

    assign bus.we       = we_q;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.drop_cnt = drop_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_accbuf_arb.sv
// Randomized bench for accbuf_arb: two instances (ADDRWIDTH 12 and 4) share
// stimulus and are compared every cycle against a queue-based model.
module tb_accbuf_arb;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            resetacc = 1'b0;
    logic [3:0]      v = '0;
    logic [3:0][31:0] x = '0;
    logic [3:0][31:0] y = '0;

    always #5 clk = ~clk;

    accbuf_arb_if #(.ADDRWIDTH(12)) b0 ();
    accbuf_arb_if #(.ADDRWIDTH(4))  b1 ();

    assign b0.acc_valid = v;
    assign b0.acc_x     = x;
    assign b0.acc_y     = y;
    assign b1.acc_valid = v;
    assign b1.acc_x     = x;
    assign b1.acc_y     = y;

    accbuf_arb #(.ADDRWIDTH(12), .FIFODEPTH(DEPTH)) u0 (
        .clk(clk), .reset(reset), .resetacc(resetacc), .bus(b0)
    );
    accbuf_arb #(.ADDRWIDTH(4), .FIFODEPTH(DEPTH)) u1 (
        .clk(clk), .reset(reset), .resetacc(resetacc), .bus(b1)
    );

    int          aw [2] = '{12, 4};
    logic [63:0] mq [0:7][$];
    int          lg [2];
    int          cnt [2][4];
    int          drp [2][4];
    bit          movf [2];
    bit          mwe [2];
    longint      maddr [2];
    logic [63:0] mdata [2];

    int nvec = 0;
    int nerr = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear(int k, bit hard);
        for (int c = 0; c < 4; c++) begin
            mq[k*4+c].delete();
            cnt[k][c] = 0;
            drp[k][c] = 0;
        end
        movf[k] = 0;
        lg[k]   = 3;
        mwe[k]  = 0;
        if (hard) begin
            maddr[k] = 0;
            mdata[k] = '0;
        end
    endtask

    task automatic model_step(int k);
        int  region;
        bit  done;
        logic [63:0] item;
        if (resetacc) begin
            model_clear(k, 0);
            return;
        end
        region = 1 << (aw[k] - 2);
        mwe[k] = 0;
        done   = 0;
        for (int i = 1; i <= 4; i++) begin
            int c;
            c = (lg[k] + i) % 4;
            if (!done && mq[k*4+c].size() > 0) begin
                done  = 1;
                item  = mq[k*4+c].pop_front();
                lg[k] = c;
                if (cnt[k][c] < region) begin
                    mwe[k]   = 1;
                    maddr[k] = c * region + cnt[k][c];
                    mdata[k] = item;
                    cnt[k][c]++;
                end else begin
                    if (drp[k][c] < 65535) drp[k][c]++;
                    movf[k] = 1;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (v[c]) begin
                if (mq[k*4+c].size() < DEPTH) begin
                    mq[k*4+c].push_back({x[c], y[c]});
                end else begin
                    if (drp[k][c] < 65535) drp[k][c]++;
                    movf[k] = 1;
                end
            end
        end
    endtask

    task automatic check_outs(int k);
        logic        awe;
        logic        aovf;
        logic [63:0] aaddr;
        logic [63:0] adata;
        logic [63:0] acnt [4];
        logic [63:0] afull [4];
        logic [63:0] adrp [4];
        int region;
        region = 1 << (aw[k] - 2);
        if (k == 0) begin
            awe = b0.we; aovf = b0.ovf;
            aaddr = 64'(b0.addr); adata = b0.data;
            for (int c = 0; c < 4; c++) begin
                acnt[c]  = 64'(b0.count[c]);
                afull[c] = 64'(b0.full[c]);
                adrp[c]  = 64'(b0.drop_cnt[c]);
            end
        end else begin
            awe = b1.we; aovf = b1.ovf;
            aaddr = 64'(b1.addr); adata = b1.data;
            for (int c = 0; c < 4; c++) begin
                acnt[c]  = 64'(b1.count[c]);
                afull[c] = 64'(b1.full[c]);
                adrp[c]  = 64'(b1.drop_cnt[c]);
            end
        end
        check($sformatf("i%0d we", k), 64'(awe), 64'(mwe[k]));
        check($sformatf("i%0d addr", k), aaddr, 64'(maddr[k]));
        check($sformatf("i%0d data", k), adata, mdata[k]);
        check($sformatf("i%0d ovf", k), 64'(aovf), 64'(movf[k]));
        for (int c = 0; c < 4; c++) begin
            check($sformatf("i%0d count%0d", k, c), acnt[c],
                  64'(cnt[k][c]));
            check($sformatf("i%0d full%0d", k, c), afull[c],
                  64'(cnt[k][c] == region));
            check($sformatf("i%0d drop%0d", k, c), adrp[c],
                  64'(drp[k][c]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            model_clear(0, 1);
            model_clear(1, 1);
        end else begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_outs(0);
        check_outs(1);
    endtask

    task automatic idle(int n);
        v = '0;
        repeat (n) cycle();
    endtask

    task automatic rand_data();
        for (int c = 0; c < 4; c++) begin
            x[c] = $urandom;
            y[c] = $urandom;
        end
    endtask

    task automatic ch0_single();
        v    = 4'b0001;
        x[0] = 32'h11;
        y[0] = 32'h22;
        cycle();
        idle(4);
    endtask

    initial begin
        model_clear(0, 1);
        model_clear(1, 1);
        #1 reset = 1'b1;
        #2;
        check_outs(0);
        check_outs(1);
        @(posedge clk);
        #1 reset = 1'b0;

        ch0_single();

        v = 4'hF;
        rand_data();
        cycle();
        idle(8);

        repeat (400) begin
            v = 4'($urandom);
            if ($urandom_range(0, 3) == 0) v = '0;
            rand_data();
            resetacc = ($urandom_range(0, 60) == 0);
            cycle();
            resetacc = 1'b0;
        end
        idle(30);

        resetacc = 1'b1;
        cycle();
        resetacc = 1'b0;
        repeat (20) begin
            v = 4'hF;
            rand_data();
            cycle();
        end
        idle(120);

        repeat (3) begin
            v = 4'hF;
            rand_data();
            cycle();
        end
        resetacc = 1'b1;
        cycle();
        resetacc = 1'b0;
        v = 4'b0100;
        rand_data();
        cycle();
        idle(4);

        resetacc = 1'b1;
        idle(1);
        resetacc = 1'b0;
        repeat (6) begin
            v = 4'b0001;
            rand_data();
            cycle();
            idle(3);
        end

        v = 4'b0001;
        rand_data();
        cycle();
        v = 4'b0011;
        rand_data();
        cycle();
        v = '0;
        #3 reset = 1'b1;
        #1;
        model_clear(0, 1);
        model_clear(1, 1);
        check_outs(0);
        check_outs(1);
        @(posedge clk);
        #1;
        check_outs(0);
        check_outs(1);
        reset = 1'b0;

        ch0_single();
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
